// File: rtl/alu_writeback_pkg.sv
// Shared types for the ALU issue/writeback stage: function encoding, flag
// register layout and the reset value of the flags.
package alu_writeback_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_INV = 3'd5
    } alu_func_e;

    typedef struct packed {
        logic z;
        logic p;
        logic c;
        logic v;
    } alu_flags_t;

    localparam alu_flags_t FLAGS_RESET = '{z: 1'b0, p: 1'b1, c: 1'b0, v: 1'b0};

    // Carry and overflow are only meaningful for the adder paths.
    function automatic logic is_arith(alu_func_e f);
        return (f == ALU_ADD) || (f == ALU_SUB);
    endfunction

    function automatic logic is_legal(logic [2:0] f);
        return f inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_INV};
    endfunction

endpackage

// File: rtl/alu_writeback_regfile.sv
// Writeback register file: NUM_REGS x DATA_W, one synchronous write port and
// one combinational read port; out-of-range addresses read 0 and drop writes.
module wb_regfile #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NUM_REGS  = 4,
    localparam int unsigned REG_IDX_W = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [REG_IDX_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic [REG_IDX_W-1:0] rd_addr,
    output logic [DATA_W-1:0]    rd_data
);

    localparam logic [REG_IDX_W:0] DEPTH = NUM_REGS[REG_IDX_W:0];

    logic [DATA_W-1:0] mem [NUM_REGS];
    logic              wr_in_range;
    logic              rd_in_range;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && wr_in_range) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_in_range) begin
            rd_data = mem[rd_addr];
        end
    end

endmodule

// File: rtl/alu_writeback.sv
// Issue/writeback stage around the ALU: accepts one op per handshake, drives the
// ALU for a single EXEC cycle, then retires the bus result into the register file.
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NUM_REGS  = 4,
    localparam int unsigned REG_IDX_W = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_func,
    input  logic [REG_IDX_W-1:0] in_dest,
    input  logic                 in_wb_en,
    input  logic                 in_flags_en,
    output logic [2:0]           alu_func,
    output logic                 alu_oe,
    input  logic [DATA_W-1:0]    bus_data,
    input  logic                 alu_z,
    input  logic                 alu_p,
    input  logic                 alu_c,
    input  logic                 alu_v,
    input  logic [REG_IDX_W-1:0] rd_addr,
    output logic [DATA_W-1:0]    rd_data,
    output logic [3:0]           flags,
    output logic                 wb_valid,
    output logic                 bad_func
);

    typedef enum logic {
        S_IDLE,
        S_EXEC
    } state_e;

    state_e                state;
    state_e                state_next;
    logic                  accept;
    logic [REG_IDX_W-1:0]  dest_q;
    logic                  wb_en_q;
    logic                  flags_en_q;
    alu_flags_t            flags_q;
    logic                  in_exec;
    logic                  legal;
    logic                  arith;
    logic                  wr_en;
    logic                  flags_upd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // alu_func is the latched func itself, so it also drives the retire decode.
    assign in_exec   = (state == S_EXEC);
    assign legal     = is_legal(alu_func);
    assign arith     = is_arith(alu_func_e'(alu_func));
    assign wr_en     = in_exec && legal && wb_en_q;
    assign flags_upd = in_exec && legal && flags_en_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_oe     <= 1'b0;
            alu_func   <= ALU_ADD;
            dest_q     <= '0;
            wb_en_q    <= 1'b0;
            flags_en_q <= 1'b0;
            flags_q    <= FLAGS_RESET;
            wb_valid   <= 1'b0;
            bad_func   <= 1'b0;
        end else begin
            alu_oe   <= accept;
            wb_valid <= in_exec;
            bad_func <= in_exec && !legal;
            if (accept) begin
                alu_func   <= in_func;
                dest_q     <= in_dest;
                wb_en_q    <= in_wb_en;
                flags_en_q <= in_flags_en;
            end
            if (flags_upd) begin
                flags_q.z <= alu_z;
                flags_q.p <= alu_p;
                if (arith) begin
                    flags_q.c <= alu_c;
                    flags_q.v <= alu_v;
                end
            end
        end
    end

    assign flags = flags_q;

    wb_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (dest_q),
        .wr_data (bus_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    a_bus_known : assert property (@(posedge clk) disable iff (rst)
        wr_en |-> !$isunknown(bus_data));

    a_cv_known : assert property (@(posedge clk) disable iff (rst)
        (flags_upd && arith) |-> !$isunknown({alu_c, alu_v}));

endmodule
